// File: rtl/ad79x8_sequencer.sv
// ad79x8_sequencer
//   Drives an AD7908/AD7918/AD7928 through an external SPI core: two
//   power-up dummy frames, one programming frame, then a continuous
//   round-robin scan over channels 0..NUM_CH-1.
//
// Parameters
//   NUM_CH      number of scanned channels (1..8)
//   RANGE_BIT   value placed in control-word bit 5 (RANGE)
//   CODING_BIT  value placed in control-word bit 4 (CODING)
//
// Ports
//   clk          clock, all logic on rising edge
//   reset        synchronous, active-high reset
//   run          high = keep scanning, low = stop after current frame
//   adc_ready    SPI core idle / frame complete
//   adc_data     word read back by the SPI core ([14:12] ID, [11:0] data)
//   ctrl_word    control word presented to the SPI core
//   initiate     one-clock frame request
//   result_data  captured conversion value
//   result_ch    channel ID of result_data
//   result_valid one-clock pulse, result_data/result_ch updated
//   ch_err       sticky channel-ID mismatch flag (only with AD79X8_SEQ_CHK_EN)
//   busy         high whenever the sequencer is not idle
//
// Build option
//   `define AD79X8_SEQ_CHK_EN adds ch_err and the channel-ID comparison.
module ad79x8_sequencer #(
   parameter int unsigned NUM_CH     = 8,
   parameter logic        RANGE_BIT  = 1'b1,
   parameter logic        CODING_BIT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        adc_ready,
   input  logic [15:0] adc_data,
   output logic [15:0] ctrl_word,
   output logic        initiate,
   output logic [11:0] result_data,
   output logic [2:0]  result_ch,
   output logic        result_valid,
`ifdef AD79X8_SEQ_CHK_EN
   output logic        ch_err,
`endif
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_LOW,
      WAIT_HIGH,
      CAPTURE
   } state_t;

   // Position in the power-up sequence; PH_RUN is the steady scan.
   typedef enum logic [1:0] {
      PH_DUMMY0,
      PH_DUMMY1,
      PH_PROGRAM,
      PH_RUN
   } phase_t;

   localparam logic [2:0] LAST_ADD = 3'(NUM_CH - 1);

   state_t     state;
   phase_t     phase;
   logic [2:0] add;        // ADD field of the next programming/scan frame
   logic [1:0] start_tmo;  // clocks spent in WAIT_LOW with adc_ready still high
`ifdef AD79X8_SEQ_CHK_EN
   logic [2:0] prev_add;   // ADD sent in the previous frame = ID expected back now
`endif

   // WRITE=1, SEQ=0, ADD, PM=11, SHADOW=0, WEAK/TRI=0, RANGE, CODING
   function automatic logic [15:0] build_word(input logic [2:0] a);
      return {1'b1, 1'b0, 1'b0, a, 2'b11, 1'b0, 1'b0, RANGE_BIT, CODING_BIT, 4'b0000};
   endfunction

   // The word depends only on counters that advance in CAPTURE, so a
   // re-issued initiate after a missed start repeats the same word.
   logic [15:0] next_word;
   always_comb begin
      next_word = 16'hFFFF;
      if (phase == PH_PROGRAM || phase == PH_RUN)
         next_word = build_word(add);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         phase        <= PH_DUMMY0;
         add          <= '0;
         start_tmo    <= '0;
         ctrl_word    <= '0;
         initiate     <= 1'b0;
         result_data  <= '0;
         result_ch    <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
`ifdef AD79X8_SEQ_CHK_EN
         prev_add     <= '0;
         ch_err       <= 1'b0;
`endif
      end else begin
         initiate     <= 1'b0;
         result_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (run) begin
                  state <= LAUNCH;
                  busy  <= 1'b1;
               end
            end
            LAUNCH: begin
               // ctrl_word only moves here, and only while the core is idle.
               if (adc_ready) begin
                  ctrl_word <= next_word;
                  initiate  <= 1'b1;
                  start_tmo <= '0;
                  state     <= WAIT_LOW;
               end
            end
            WAIT_LOW: begin
               if (!adc_ready)
                  state <= WAIT_HIGH;
               else if (start_tmo == 2'd3)
                  state <= LAUNCH;
               else
                  start_tmo <= start_tmo + 2'd1;
            end
            WAIT_HIGH: begin
               // One settle clock: data is sampled in CAPTURE, not here.
               if (adc_ready)
                  state <= CAPTURE;
            end
            CAPTURE: begin
               if (phase == PH_RUN) begin
                  result_valid <= 1'b1;
                  result_data  <= adc_data[11:0];
                  result_ch    <= adc_data[14:12];
`ifdef AD79X8_SEQ_CHK_EN
                  if (adc_data[14:12] != prev_add)
                     ch_err <= 1'b1;
`endif
               end
               unique case (phase)
                  PH_DUMMY0:  phase <= PH_DUMMY1;
                  PH_DUMMY1:  phase <= PH_PROGRAM;
                  default:    phase <= PH_RUN;
               endcase
               if (phase == PH_PROGRAM || phase == PH_RUN) begin
`ifdef AD79X8_SEQ_CHK_EN
                  prev_add <= add;
`endif
                  add <= (add == LAST_ADD) ? 3'd0 : add + 3'd1;
               end
               state <= run ? LAUNCH : IDLE;
               busy  <= run;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ad79x8_sequencer.sv
module tb_ad79x8_sequencer;

   localparam int unsigned NCH = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        adc_ready = 1'b1;
   logic [15:0] adc_data = '0;
   logic [15:0] ctrl_word;
   logic        initiate;
   logic [11:0] result_data;
   logic [2:0]  result_ch;
   logic        result_valid;
   logic        busy;
`ifdef AD79X8_SEQ_CHK_EN
   logic        ch_err;
`endif

   always #5 clk = ~clk;

   ad79x8_sequencer #(
      .NUM_CH(NCH),
      .RANGE_BIT(1'b1),
      .CODING_BIT(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .adc_ready(adc_ready),
      .adc_data(adc_data),
      .ctrl_word(ctrl_word),
      .initiate(initiate),
      .result_data(result_data),
      .result_ch(result_ch),
      .result_valid(result_valid),
`ifdef AD79X8_SEQ_CHK_EN
      .ch_err(ch_err),
`endif
      .busy(busy)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Frame k after reset: two dummies, then ADD = (k-2) mod NCH over 16'h8330.
   function automatic logic [15:0] exp_word(input int unsigned k);
      if (k < 2) return 16'hFFFF;
      return 16'h8330 | 16'(((k - 2) % NCH) << 10);
   endfunction

   // ADC / SPI-core model and scoreboard state
   int unsigned k = 0;            // frames started since reset (retries not counted)
   int unsigned frame_idx = 0;
   int unsigned cyc = 0;
   int unsigned n_init = 0;
   int unsigned ign_cyc = 0;
   int unsigned fixed_len = 0;
   int unsigned cnt = 0;
   logic        ignore_one = 1'b0;
   logic        retry_pending = 1'b0;
   logic        retry_done = 1'b0;
   logic        stall = 1'b0;
   logic        force_id5 = 1'b0;
   logic        force_hit = 1'b0;
   logic [15:0] retry_word = '0;
   logic [15:0] last_sent = '0;
   logic [15:0] last_cw = '0;
   logic [15:0] ret_word = '0;
   logic [14:0] expq[$];
   logic [15:0] obs_word [64];
   logic        obs_valid[64];
   logic [2:0]  obs_ch   [64];

   initial begin
      logic        rdy_at_edge;
      logic        start;
      logic [2:0]  id;
      logic [11:0] conv;
      logic [14:0] e;
      for (int i = 0; i < 64; i++) begin
         obs_word[i] = '0; obs_valid[i] = 1'b0; obs_ch[i] = '0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         rdy_at_edge = adc_ready;
         start = 1'b0;
         if (reset) begin
            k = 0;
            expq.delete();
            retry_pending = 1'b0;
            cnt = 0;
            last_sent = '0;
            for (int i = 0; i < 64; i++) begin
               obs_word[i] = '0; obs_valid[i] = 1'b0; obs_ch[i] = '0;
            end
         end else begin
            if (!rdy_at_edge)
               check("ctrl_word_stable_while_busy", ctrl_word, last_cw);
            if (result_valid) begin
               if (expq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL spurious_result_valid: got 1 expected 0 (frame %0d)", k);
               end else begin
                  e = expq.pop_front();
                  check("result_ch", result_ch, e[14:12]);
                  check("result_data", result_data, e[11:0]);
               end
               if (k > 0 && k <= 64) begin
                  check("single_valid_per_frame", obs_valid[k-1], 0);
                  obs_valid[k-1] = 1'b1;
                  obs_ch[k-1] = result_ch;
               end
            end
            if (!adc_ready && !stall) begin
               if (cnt > 0) cnt--;
               if (cnt == 0) begin
                  adc_ready = 1'b1;
                  adc_data = ret_word;
               end else begin
                  adc_data = 16'($urandom);
               end
            end
            if (initiate) begin
               n_init++;
               check("initiate_only_when_ready", rdy_at_edge, 1);
               if (retry_pending) begin
                  check("retry_ctrl_word", ctrl_word, retry_word);
                  checks++;
                  if (cyc - ign_cyc < 5 || cyc - ign_cyc > 6) begin
                     errors++;
                     $display("FAIL retry_gap: got %0d clks expected 5..6", cyc - ign_cyc);
                  end
                  retry_pending = 1'b0;
                  retry_done = 1'b1;
                  start = 1'b1;
               end else begin
                  check("ctrl_word", ctrl_word, exp_word(k));
                  if (k < 64) obs_word[k] = ctrl_word;
                  frame_idx = k;
                  k++;
                  if (ignore_one) begin
                     ignore_one = 1'b0;
                     retry_pending = 1'b1;
                     retry_word = ctrl_word;
                     ign_cyc = cyc;
                  end else begin
                     start = 1'b1;
                  end
               end
               if (start) begin
                  // The converter returns the channel addressed by the previous frame.
                  id = last_sent[12:10];
                  if (force_id5 && frame_idx >= 3 && id == 3'd2) begin
                     id = 3'd5;
                     force_id5 = 1'b0;
                     force_hit = 1'b1;
                  end
                  conv = 12'($urandom);
                  ret_word = {1'b0, id, conv};
                  if (frame_idx >= 3) expq.push_back({id, conv});
                  last_sent = ctrl_word;
                  adc_ready = 1'b0;
                  adc_data = 16'($urandom);
                  cnt = (fixed_len != 0) ? fixed_len : $urandom_range(1, 6);
               end
            end
         end
         last_cw = ctrl_word;
      end
   end

   task automatic step(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_frames(input int unsigned target);
      int unsigned t = 0;
      while (k < target && t < 3000) begin
         step(1);
         t++;
      end
      check("wait_frames_reached", 32'(k >= target), 1);
   endtask

   task automatic wait_initiate();
      int unsigned t = 0;
      while (!initiate && t < 300) begin
         step(1);
         t++;
      end
      check("wait_initiate_seen", initiate, 1);
   endtask

   typedef struct packed {
      logic [15:0] word;
      logic        valid;
      logic [2:0]  ch;
   } vec_t;

   initial begin
      vec_t        tbl[8];
      int unsigned t;
      int unsigned n0;

      tbl[0] = '{word: 16'hFFFF, valid: 1'b0, ch: 3'd0};
      tbl[1] = '{word: 16'hFFFF, valid: 1'b0, ch: 3'd0};
      tbl[2] = '{word: 16'h8330, valid: 1'b0, ch: 3'd0};
      tbl[3] = '{word: 16'h8730, valid: 1'b1, ch: 3'd0};
      tbl[4] = '{word: 16'h8B30, valid: 1'b1, ch: 3'd1};
      tbl[5] = '{word: 16'h8330, valid: 1'b1, ch: 3'd2};
      tbl[6] = '{word: 16'h8730, valid: 1'b1, ch: 3'd0};
      tbl[7] = '{word: 16'h8B30, valid: 1'b1, ch: 3'd1};

      // Reset state
      step(3);
      check("rst_ctrl_word", ctrl_word, 16'h0000);
      check("rst_initiate", initiate, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_result_data", result_data, 0);
      check("rst_result_ch", result_ch, 0);
      check("rst_busy", busy, 0);
`ifdef AD79X8_SEQ_CHK_EN
      check("rst_ch_err", ch_err, 0);
`endif

      // Power-up sequence and channel wrap, table driven
      reset = 1'b0;
      run = 1'b1;
      wait_frames(9);
      check("busy_while_running", busy, 1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("tbl%0d_word", i), obs_word[i], tbl[i].word);
         check($sformatf("tbl%0d_valid", i), obs_valid[i], tbl[i].valid);
         if (tbl[i].valid)
            check($sformatf("tbl%0d_ch", i), obs_ch[i], tbl[i].ch);
      end

      // Missed frame start: initiate re-issued with the same word
      retry_done = 1'b0;
      ignore_one = 1'b1;
      t = 0;
      while (!retry_done && t < 300) begin step(1); t++; end
      check("retry_reissued", retry_done, 1);

      // run dropped while waiting for the frame to finish
      fixed_len = 4;
      wait_initiate();
      step(1);
      run = 1'b0;
      t = 0;
      while (!result_valid && t < 40) begin step(1); t++; end
      check("run_drop_result_delivered", result_valid, 1);
      step(1);
      check("run_drop_busy_low", busy, 0);
      n0 = n_init;
      step(10);
      check("run_drop_no_initiate", n_init, n0);
      check("run_drop_still_idle", busy, 0);
      check("run_drop_no_pending", expq.size(), 0);

      // Resume: sequence continues, first readback is already valid
      run = 1'b1;
      fixed_len = 0;
      wait_frames(k + 4);

`ifdef AD79X8_SEQ_CHK_EN
      check("ch_err_before_fault", ch_err, 0);
      force_hit = 1'b0;
      force_id5 = 1'b1;
      t = 0;
      while (!force_hit && t < 500) begin step(1); t++; end
      check("ch_err_fault_injected", force_hit, 1);
      wait_frames(k + 2);
      check("ch_err_set", ch_err, 1);
      wait_frames(k + 3);
      check("ch_err_sticky", ch_err, 1);
`endif

      // Reset in the middle of a frame with the core stuck busy
      fixed_len = 3;
      wait_initiate();
      stall = 1'b1;
      step(1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("midrst_ctrl_word", ctrl_word, 16'h0000);
      check("midrst_busy", busy, 0);
      check("midrst_result_data", result_data, 0);
      check("midrst_result_ch", result_ch, 0);
      check("midrst_result_valid", result_valid, 0);
`ifdef AD79X8_SEQ_CHK_EN
      check("midrst_ch_err", ch_err, 0);
`endif
      n0 = n_init;
      step(20);
      check("midrst_no_initiate_while_busy", n_init, n0);
      check("midrst_waiting_busy", busy, 1);
      stall = 1'b0;
      fixed_len = 0;
      wait_frames(4);
      check("midrst_dummy0", obs_word[0], 16'hFFFF);
      check("midrst_dummy1", obs_word[1], 16'hFFFF);
      check("midrst_program", obs_word[2], 16'h8330);

      // Random run toggling, random frame lengths and missed starts
      for (int c = 0; c < 800; c++) begin
         step(1);
         if ($urandom_range(0, 29) == 0) run = ~run;
         if ($urandom_range(0, 149) == 0) ignore_one = 1'b1;
      end

      // Drain
      run = 1'b0;
      ignore_one = 1'b0;
      t = 0;
      while (busy && t < 300) begin step(1); t++; end
      check("drain_idle", busy, 0);
      step(5);
      check("drain_all_results_delivered", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ad79x8_sequencer.md
AD79X8_SEQUENCER -- requirements
Module: ad79x8_sequencer

Interface
REQ-001 Parameter NUM_CH, default 8, number of scanned channels (1..8); scan order 0..NUM_CH-1.
REQ-002 Parameter RANGE_BIT, default 1'b1, value driven into control-word bit 5 (RANGE).
REQ-003 Parameter CODING_BIT, default 1'b1, value driven into control-word bit 4 (CODING, straight binary).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 run  in  1  level; high = scan continuously, low = stop after current frame.
REQ-007 adc_ready  in  1  ready/cs from SPI core; high = idle/frame complete.
REQ-008 adc_data  in  16  word read back by SPI core; [14:12] channel ID, [11:0] conversion.
REQ-009 ctrl_word  out  16  control word presented to SPI core bus input.
REQ-010 initiate  out  1  one-clk pulse requesting an SPI frame.
REQ-011 result_data  out  12  captured conversion value.
REQ-012 result_ch  out  3  channel ID of result_data.
REQ-013 result_valid  out  1  one-clk pulse, result_data/result_ch valid.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 ch_err  out  1  sticky channel-mismatch flag (present only with macro, REQ-034).

Function
REQ-016 States: IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, CAPTURE; one state register.
REQ-017 IDLE -> LAUNCH when run=1; otherwise stay.
REQ-018 LAUNCH: when adc_ready=1, pulse initiate for exactly one clk with ctrl_word stable, go WAIT_LOW; if adc_ready=0, hold without pulsing.
REQ-019 WAIT_LOW -> WAIT_HIGH on first clk with adc_ready=0; a frame not started within 4 clks returns to LAUNCH and re-issues initiate.
REQ-020 WAIT_HIGH -> CAPTURE on first clk with adc_ready=1; CAPTURE samples adc_data one clk after ready rises (settle cycle).
REQ-021 CAPTURE -> LAUNCH if run=1, else IDLE; ctrl_word never changes while adc_ready=0.
REQ-022 Power-up: first two frames after reset are dummy frames with ctrl_word=16'hFFFF; no result_valid for them.
REQ-023 Third frame (first programming) ctrl_word = WRITE=1, SEQ=0, ADD=0, PM=2'b11, SHADOW=0, RANGE_BIT, CODING_BIT, other bits 0 (16'h8330 for defaults); its readback is discarded.
REQ-024 Subsequent frames: ADD = (previous ADD+1) mod NUM_CH; NUM_CH=1 keeps ADD=0.
REQ-025 result_valid pulses in CAPTURE for every frame after the first programming frame; result_ch=adc_data[14:12], result_data=adc_data[11:0].
REQ-026 result_data/result_ch hold last value between pulses; at most one pulse per frame; latency CAPTURE = 1 clk after adc_ready rise.
REQ-027 run falling mid-frame: frame completes, its result is delivered, then IDLE; dummy frames not repeated.
REQ-028 run rising again from IDLE: resumes at next ADD in sequence, first frame readback valid (pipeline preserved).
REQ-029 busy=1 in all states except IDLE.

Reset
REQ-030 reset=1 at a rising edge: state IDLE, ctrl_word=16'h0000, initiate=0, result_valid=0, result_data=0, result_ch=0, ADD=0, dummy counter cleared, ch_err=0.
REQ-031 Reset mid-frame: next frame re-runs both dummy frames; LAUNCH waits for adc_ready=1 before initiate.
REQ-032 reset dominates run and all other inputs.

Configuration
REQ-033 Macro AD79X8_SEQ_CHK_EN selects channel-ID checking.
REQ-034 Defined: ch_err port exists; sets when a valid readback's [14:12] differs from ADD sent the previous frame; cleared only by reset; result_valid still pulses.
REQ-035 Undefined: no ch_err port, no comparison logic; all other behaviour identical.

Verification
REQ-036 reset, run=1, ADC model ready: ctrl_word 16'hFFFF, 16'hFFFF, then 16'h8330, 16'h8730, 16'h8B30; first result_valid in fourth frame with result_ch=0.
REQ-037 NUM_CH=3, run held: result_ch sequence 0,1,2,0,1; ctrl_word ADD wraps 2->0.
REQ-038 run dropped during WAIT_HIGH: frame result delivered, busy=0 one clk later, initiate stays 0.
REQ-039 reset asserted in WAIT_HIGH with adc_ready=0 for 20 clks: no initiate until adc_ready=1, then two 16'hFFFF frames.
REQ-040 macro defined, model returns ID 5 when ADD 2 expected: ch_err=1 and stays 1 until reset; undefined build: no ch_err port.
REQ-041 adc_ready held high after initiate (missed start): initiate re-pulsed after 4 clks, ctrl_word unchanged.
